// File: rtl/crop_pkg.sv
// crop_pkg: shared definitions for the crop frame sequencer.
//   - crop_state_e      : sequencer state encoding (IDLE / ARMED / ACTIVE)
//   - crop_xw / crop_yw : coordinate widths able to hold 0..COLS / 0..ROWS
//   - CROP_IN_*_DEF     : default frame size; the full frame is also the
//                         reset-time crop window (0,0,IN_COLS,IN_ROWS)
package crop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_E   = 2'd0,
    ST_ARMED_E  = 2'd1,
    ST_ACTIVE_E = 2'd2
  } crop_state_e;

  localparam int CROP_IN_COLS_DEF = 40;
  localparam int CROP_IN_ROWS_DEF = 40;

  // Width large enough to hold the value 'cols' itself (window widths reach IN_COLS).
  function automatic int crop_xw(input int cols);
    return $clog2(cols + 1);
  endfunction

  function automatic int crop_yw(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/crop_frame_ctrl_if.sv
// crop_frame_ctrl_if: pixel-side handshake of the crop sequencer.
//   pix_fire  : pixel accepted this cycle (source -> sequencer)
//   pix_sof   : qualifies pix_fire, pixel is first of a frame
//   keep      : registered, pixel accepted last cycle is inside the window
//   keep_sof  : with keep, first kept pixel of the frame
//   keep_eol  : with keep, last kept pixel of a window row
//   keep_eof  : with keep, last kept pixel of the frame
// master = pixel source / datapath side, slave = crop_frame_ctrl.
interface crop_frame_ctrl_if;

  logic pix_fire;
  logic pix_sof;
  logic keep;
  logic keep_sof;
  logic keep_eol;
  logic keep_eof;

  modport master (
    output pix_fire, pix_sof,
    input  keep, keep_sof, keep_eol, keep_eof
  );

  modport slave (
    input  pix_fire, pix_sof,
    output keep, keep_sof, keep_eol, keep_eof
  );

endinterface

// File: rtl/crop_coord_counter.sv
// crop_coord_counter: (x,y) position tracker for accepted pixels.
//   clk, reset  : clock, synchronous active-high reset
//   fire        : pixel accepted this cycle
//   sof         : start of frame (already qualified by fire)
//   cur_x/cur_y : coordinates of the pixel presented this cycle (sof forces 0,0)
//   at_origin   : the next expected pixel is (0,0)
//   last        : the current pixel is (COLS-1, ROWS-1)
module crop_coord_counter
  import crop_pkg::*;
#(
  parameter  int COLS = CROP_IN_COLS_DEF,
  parameter  int ROWS = CROP_IN_ROWS_DEF,
  localparam int XW   = crop_xw(COLS),
  localparam int YW   = crop_yw(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fire,
  input  logic          sof,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          at_origin,
  output logic          last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    cur_x = sof ? '0 : x_q;
    cur_y = sof ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (fire) begin
      if (cur_x == XW'(COLS - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(ROWS - 1)) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  assign at_origin = (x_q == '0) && (y_q == '0);
  assign last      = (cur_x == XW'(COLS - 1)) && (cur_y == YW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/crop_frame_ctrl.sv
// crop_frame_ctrl: frame-level sequencer for the crop datapath.
// Tracks the position of every accepted pixel, holds a staged/shadowed crop
// window (shadow reloads only at frame start) and arms capture per frame,
// single-shot or continuous. keep/keep_sof/keep_eol/keep_eof are registered so
// they line up with the datapath's registered pixel_out.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cfg_we            write cfg_x1/cfg_y1/cfg_w/cfg_h into staging
//   start / stop      arm capture / finish current frame then idle (pulses)
//   continuous        re-arm after each frame (sampled at frame end)
//   pix (slave)       pix_fire/pix_sof in, keep* strobes out
//   frame_done        pulse one cycle after the last pixel of an active frame
//   frame_cnt         completed frames, wraps
//   busy              state != IDLE
//   sync_err          pulse: pix_sof arrived mid-frame while ACTIVE
//   cfg_err           pulse: rejected window at shadow load
//
// Build option: define CROP_CFG_CHECK_EN to reject empty / out-of-frame
// windows (frame still runs, keep forced low). Without it, cfg_err is 0 and
// oversized windows are clipped to the frame.
//
// state  | meaning
// IDLE   | not capturing; stop_pend cleared
// ARMED  | waiting for the first pixel of a frame (pix_sof)
// ACTIVE | capturing; keep evaluated against the shadow window
module crop_frame_ctrl
  import crop_pkg::*;
#(
  parameter  int IN_ROWS = CROP_IN_ROWS_DEF,
  parameter  int IN_COLS = CROP_IN_COLS_DEF,
  parameter  int CNT_W   = 16,
  localparam int XW      = crop_xw(IN_COLS),
  localparam int YW      = crop_yw(IN_ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [XW-1:0]    cfg_x1,
  input  logic [YW-1:0]    cfg_y1,
  input  logic [XW-1:0]    cfg_w,
  input  logic [YW-1:0]    cfg_h,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  crop_frame_ctrl_if.slave pix,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             sync_err,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE   = ST_IDLE_E;
  localparam logic [1:0] ST_ARMED  = ST_ARMED_E;
  localparam logic [1:0] ST_ACTIVE = ST_ACTIVE_E;

  logic [1:0]       state_q, state_d;
  logic             stop_pend_q, stop_pend_d;

  logic [XW-1:0]    stg_x1_q, stg_w_q, shd_x1_q, shd_w_q;
  logic [YW-1:0]    stg_y1_q, stg_h_q, shd_y1_q, shd_h_q;

  logic             keep_q, keep_sof_q, keep_eol_q, keep_eof_q;
  logic             keep_d, keep_sof_d, keep_eol_d, keep_eof_d;
  logic             done_q, sync_err_q, cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] frame_cnt_q;

  logic             fire, sof;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic             at_origin, last_px;

  logic             arm_entry, act_start, resync, load, frame_last, px_active;
  logic [XW-1:0]    win_x1, win_w;
  logic [YW-1:0]    win_y1, win_h;
  logic [XW:0]      x_end, x_lim;
  logic [YW:0]      y_end, y_lim;
  logic             in_x, in_y, at_eol, at_last_row, win_bad;

  assign fire = pix.pix_fire;
  assign sof  = pix.pix_sof & pix.pix_fire;

  crop_coord_counter #(
    .COLS (IN_COLS),
    .ROWS (IN_ROWS)
  ) u_coord (
    .clk       (clk),
    .reset     (reset),
    .fire      (fire),
    .sof       (sof),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .at_origin (at_origin),
    .last      (last_px)
  );

  // Frame start while ACTIVE is either the natural wrap to (0,0) or a pix_sof
  // that resyncs an aborted frame; both reload the shadow window.
  assign arm_entry  = (state_q == ST_ARMED) && sof && !stop;
  assign act_start  = (state_q == ST_ACTIVE) && fire && (sof || at_origin);
  assign resync     = (state_q == ST_ACTIVE) && sof && !at_origin;
  assign load       = arm_entry || act_start;
  assign frame_last = (state_q == ST_ACTIVE) && fire && last_px;
  assign px_active  = fire && ((state_q == ST_ACTIVE) || arm_entry);

  // On the load cycle the pixel is judged against the window being loaded
  // (staging as it was before any same-cycle cfg_we).
  always_comb begin
    win_x1 = load ? stg_x1_q : shd_x1_q;
    win_y1 = load ? stg_y1_q : shd_y1_q;
    win_w  = load ? stg_w_q  : shd_w_q;
    win_h  = load ? stg_h_q  : shd_h_q;
  end

  // One extra bit so x1+w / y1+h never wrap.
  always_comb begin
    x_end = {1'b0, win_x1} + {1'b0, win_w};
    y_end = {1'b0, win_y1} + {1'b0, win_h};
    x_lim = (x_end > (XW+1)'(IN_COLS)) ? (XW+1)'(IN_COLS) : x_end;
    y_lim = (y_end > (YW+1)'(IN_ROWS)) ? (YW+1)'(IN_ROWS) : y_end;
  end

  always_comb begin
    in_x        = (cur_x >= win_x1) && ({1'b0, cur_x} < x_end);
    in_y        = (cur_y >= win_y1) && ({1'b0, cur_y} < y_end);
    at_eol      = (({1'b0, cur_x} + (XW+1)'(1)) == x_lim);
    at_last_row = (({1'b0, cur_y} + (YW+1)'(1)) == y_lim);
  end

`ifdef CROP_CFG_CHECK_EN
  // Shadow holds the window for the whole frame, so checking the selected
  // window every cycle keeps keep suppressed for the full rejected frame.
  assign win_bad   = (win_w == '0) || (win_h == '0) ||
                     (x_end > (XW+1)'(IN_COLS)) || (y_end > (YW+1)'(IN_ROWS));
  assign cfg_err_d = load && win_bad;
`else
  assign win_bad   = 1'b0;
  assign cfg_err_d = 1'b0;
`endif

  always_comb begin
    keep_d     = px_active && in_x && in_y && !win_bad;
    keep_sof_d = keep_d && (cur_x == win_x1) && (cur_y == win_y1);
    keep_eol_d = keep_d && at_eol;
    keep_eof_d = keep_eol_d && at_last_row;
  end

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stop)     state_d = ST_IDLE;
        else if (sof) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (stop) stop_pend_d = 1'b1;
        if (frame_last && !(continuous && !stop_pend_q && !stop)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      stg_x1_q    <= '0;
      stg_y1_q    <= '0;
      stg_w_q     <= XW'(IN_COLS);
      stg_h_q     <= YW'(IN_ROWS);
      shd_x1_q    <= '0;
      shd_y1_q    <= '0;
      shd_w_q     <= XW'(IN_COLS);
      shd_h_q     <= YW'(IN_ROWS);
      keep_q      <= 1'b0;
      keep_sof_q  <= 1'b0;
      keep_eol_q  <= 1'b0;
      keep_eof_q  <= 1'b0;
      done_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      if (cfg_we) begin
        stg_x1_q <= cfg_x1;
        stg_y1_q <= cfg_y1;
        stg_w_q  <= cfg_w;
        stg_h_q  <= cfg_h;
      end
      if (load) begin
        shd_x1_q <= stg_x1_q;
        shd_y1_q <= stg_y1_q;
        shd_w_q  <= stg_w_q;
        shd_h_q  <= stg_h_q;
      end
      keep_q     <= keep_d;
      keep_sof_q <= keep_sof_d;
      keep_eol_q <= keep_eol_d;
      keep_eof_q <= keep_eof_d;
      done_q     <= frame_last;
      sync_err_q <= resync;
      cfg_err_q  <= cfg_err_d;
      if (frame_last) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assign pix.keep     = keep_q;
  assign pix.keep_sof = keep_sof_q;
  assign pix.keep_eol = keep_eol_q;
  assign pix.keep_eof = keep_eof_q;
  assign frame_done   = done_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = (state_q != ST_IDLE);
  assign sync_err     = sync_err_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_crop_frame_ctrl.sv
module tb_crop_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_x1 = '0, cfg_y1 = '0, cfg_w = '0, cfg_h = '0;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic        frame_done, busy, sync_err, cfg_err;
  logic [15:0] frame_cnt;

  crop_frame_ctrl_if pix_if ();

  crop_frame_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_x1     (cfg_x1),
    .cfg_y1     (cfg_y1),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .pix        (pix_if),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .busy       (busy),
    .sync_err   (sync_err),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] fl;   // {sof, eol, eof}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_err = 0;
  int   keep_n = 0, done_n = 0, sync_n = 0, cerr_n = 0;
  logic fire_prev = 1'b0;

  // expected window for the frame currently being streamed
  int ew_x1, ew_y1, ew_w, ew_h;
  bit ew_bad = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents keep.
  always @(negedge clk) begin
    if (pix_if.keep === 1'b1) begin
      keep_n++;
      check("keep_follows_fire", int'(fire_prev), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_keep", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("keep_flags@(%0d,%0d)", e.x, e.y),
              int'({pix_if.keep_sof, pix_if.keep_eol, pix_if.keep_eof}), int'(e.fl));
      end
    end
    if (frame_done === 1'b1) done_n++;
    if (sync_err === 1'b1)   sync_n++;
    if (cfg_err === 1'b1)    cerr_n++;
    fire_prev = pix_if.pix_fire;
  end

  function automatic void expect_px(input int x, input int y);
    int   xe, ye;
    exp_t e;
    xe = (ew_x1 + ew_w > 40) ? 40 : ew_x1 + ew_w;
    ye = (ew_y1 + ew_h > 40) ? 40 : ew_y1 + ew_h;
    if (!ew_bad && x >= ew_x1 && x < ew_x1 + ew_w && y >= ew_y1 && y < ew_y1 + ew_h) begin
      e.x  = x;
      e.y  = y;
      e.fl = {(x == ew_x1 && y == ew_y1), (x == xe - 1), (x == xe - 1 && y == ye - 1)};
      exp_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pix_if.pix_fire = 1'b0;
    pix_if.pix_sof = 1'b0;
  endtask

  task automatic set_cfg(input int x1, input int y1, input int w, input int h);
    cfg_we = 1'b1;
    cfg_x1 = 6'(x1);
    cfg_y1 = 6'(y1);
    cfg_w  = 6'(w);
    cfg_h  = 6'(h);
  endtask

  task automatic set_ew(input int x1, input int y1, input int w, input int h);
    ew_x1 = x1; ew_y1 = y1; ew_w = w; ew_h = h;
  endtask

  // Streams pixel indices first..last of a 40x40 frame; index 0 carries pix_sof.
  task automatic stream(input int first, input int last, input bit act, input int gapmod);
    for (int i = first; i <= last; i++) begin
      if (act) expect_px(i % 40, i / 40);
      pix_if.pix_fire = 1'b1;
      pix_if.pix_sof  = (i == 0);
      tick();
      if (gapmod > 0) repeat (i % gapmod) tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    continuous = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic end_test(input string t, input int keeps, input int dones,
                          input int cnt, input int syncs, input int cerrs);
    repeat (4) tick();
    check({t, "_queue_left"}, exp_q.size(), 0);
    check({t, "_keeps"}, keep_n, keeps);
    check({t, "_frame_done"}, done_n, dones);
    check({t, "_frame_cnt"}, int'(frame_cnt), cnt);
    check({t, "_sync_err"}, sync_n, syncs);
    check({t, "_cfg_err"}, cerr_n, cerrs);
    check({t, "_busy"}, int'(busy), 0);
    exp_q.delete();
    keep_n = 0; done_n = 0; sync_n = 0; cerr_n = 0;
  endtask

  initial begin
    pix_if.pix_fire = 1'b0;
    pix_if.pix_sof  = 1'b0;
    do_reset();
    check("rst_keep", int'(pix_if.keep), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_sync_err", int'(sync_err), 0);
    check("rst_cfg_err", int'(cfg_err), 0);

    // single shot, window (10,10,20,20); a following frame is not captured
    set_cfg(10, 10, 20, 20); tick();
    start = 1'b1; tick();
    check("armed_busy", int'(busy), 1);
    set_ew(10, 10, 20, 20);
    stream(0, 1599, 1'b1, 0);
    repeat (2) tick();
    check("single_idle", int'(busy), 0);
    stream(0, 1599, 1'b0, 0);
    end_test("single", 400, 1, 1, 0, 0);

    // continuous; cfg change mid-frame 1 and on the frame-2 start cycle
    do_reset();
    continuous = 1'b1;
    set_cfg(10, 10, 20, 20); tick();
    start = 1'b1; tick();
    set_ew(10, 10, 20, 20);
    stream(0, 799, 1'b1, 0);
    set_cfg(0, 0, 5, 5);
    stream(800, 1599, 1'b1, 0);
    set_ew(0, 0, 5, 5);
    set_cfg(2, 2, 3, 3);
    stream(0, 1599, 1'b1, 0);
    set_ew(2, 2, 3, 3);
    stream(0, 99, 1'b1, 0);
    continuous = 1'b0;
    stream(100, 1599, 1'b1, 0);
    end_test("cont", 434, 3, 3, 0, 0);

    // pix_sof at pixel 700 resyncs and restarts the frame
    do_reset();
    set_cfg(10, 10, 20, 20); tick();
    start = 1'b1; tick();
    set_ew(10, 10, 20, 20);
    stream(0, 699, 1'b1, 0);
    stream(0, 1599, 1'b1, 0);
    end_test("resync", 550, 1, 1, 1, 0);

    // idle gaps of 0..3 cycles between fires
    do_reset();
    set_cfg(10, 10, 20, 20); tick();
    start = 1'b1; tick();
    set_ew(10, 10, 20, 20);
    stream(0, 1599, 1'b1, 4);
    end_test("gaps", 400, 1, 1, 0, 0);

    // stop at pixel 100 while continuous: frame completes, then idle
    do_reset();
    continuous = 1'b1;
    set_cfg(10, 10, 20, 20); tick();
    start = 1'b1; tick();
    set_ew(10, 10, 20, 20);
    stream(0, 99, 1'b1, 0);
    stop = 1'b1;
    stream(100, 1599, 1'b1, 0);
    repeat (2) tick();
    check("stop_idle", int'(busy), 0);
    stream(0, 1599, 1'b0, 0);
    end_test("stop", 400, 1, 1, 0, 0);

    // window crossing the right frame edge
    do_reset();
    set_cfg(35, 0, 10, 40); tick();
    start = 1'b1; tick();
    set_ew(35, 0, 10, 40);
`ifdef CROP_CFG_CHECK_EN
    ew_bad = 1'b1;
    stream(0, 1599, 1'b1, 0);
    end_test("clip", 0, 1, 1, 0, 1);
`else
    stream(0, 1599, 1'b1, 0);
    end_test("clip", 200, 1, 1, 0, 0);
`endif
    ew_bad = 1'b0;

    // reset mid-frame restores idle state and the full-frame window
    do_reset();
    set_cfg(10, 10, 20, 20); tick();
    start = 1'b1; tick();
    set_ew(10, 10, 20, 20);
    stream(0, 300, 1'b1, 0);
    reset = 1'b1; tick();
    check("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    end_test("midrst", 0, 0, 0, 0, 0);
    start = 1'b1; tick();
    set_ew(0, 0, 40, 40);
    stream(0, 1599, 1'b1, 0);
    end_test("fullwin", 1600, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
